// File: rtl/elliptic_curve_structs.sv
// Shared curve types: affine point, the point-at-infinity encoding and the
// bucket-accumulator state enum.
package elliptic_curve_structs;

   localparam int COORD_W = 32;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } curve_point_t;

   // All-ones coordinates never occur on a valid affine point, so they encode infinity.
   localparam curve_point_t inf_point = '{x: {COORD_W{1'b1}}, y: {COORD_W{1'b1}}};

   typedef enum logic [3:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_ARM,
      ST_ADD,
      ST_WRITE,
      ST_DRAIN_RD,
      ST_DRAIN
   } bucket_state_t;

   function automatic logic pt_is_inf(input curve_point_t p);
      return p == inf_point;
   endfunction

endpackage

// File: rtl/msm_bucket_store.sv
// Bucket RAM: one synchronous write port and one synchronous read port with a
// registered output that holds its value between reads.
module msm_bucket_store
   import elliptic_curve_structs::*;
#(
   parameter int NUM_BUCKETS = 16,
   parameter int IDX_W       = $clog2(NUM_BUCKETS)
) (
   input  logic               clk,
   input  logic               rd_en_i,
   input  logic [IDX_W-1:0]   rd_addr_i,
   output curve_point_t       rd_data_o,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_addr_i,
   input  curve_point_t       wr_data_i
);

   curve_point_t mem_q [NUM_BUCKETS];
   curve_point_t rd_data_q;

   // NOTE: the array has no reset; the owner sweeps it with inf_point after every reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/msm_bucket_accumulator.sv
// MSM bucket stage: accumulates (point, bucket) pairs through an external point
// adder, screens the cases the adder cannot handle, and drains buckets on request.
module msm_bucket_accumulator
   import elliptic_curve_structs::*;
#(
   parameter int NUM_BUCKETS    = 16,
   parameter int IDX_W          = $clog2(NUM_BUCKETS),
   parameter int MAX_ADD_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  curve_point_t       in_point,
   input  logic [IDX_W-1:0]   in_idx,
   input  logic               drain_start,
   output logic               out_valid,
   input  logic               out_ready,
   output curve_point_t       out_point,
   output logic [IDX_W-1:0]   out_idx,
   output logic               add_reset,
   output curve_point_t       add_P,
   output curve_point_t       add_Q,
   input  logic               add_done,
   input  curve_point_t       add_R,
   output logic               err_double,
   output logic               err_timeout,
   output logic               busy
);

   localparam int                 CNT_W    = $clog2(MAX_ADD_CYCLES + 1);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BUCKETS - 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_ADD_CYCLES - 1);

   bucket_state_t       state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    idx_q;
   curve_point_t        q_q;
   curve_point_t        b_q;
   curve_point_t        wr_val_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                add_reset_q;
   logic                out_valid_q;
   logic                err_double_q;
   logic                err_timeout_q;

   logic                rd_en_d;
   logic [IDX_W-1:0]    rd_addr_d;
   logic                wr_en_d;
   logic [IDX_W-1:0]    wr_addr_d;
   curve_point_t        wr_data_d;
   curve_point_t        rd_data;

   msm_bucket_store #(
      .NUM_BUCKETS (NUM_BUCKETS),
      .IDX_W       (IDX_W)
   ) u_store (
      .clk       (clk),
      .rd_en_i   (rd_en_d),
      .rd_addr_i (rd_addr_d),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en_d),
      .wr_addr_i (wr_addr_d),
      .wr_data_i (wr_data_d)
   );

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      rd_en_d   = 1'b0;
      rd_addr_d = idx_q;
      wr_en_d   = 1'b0;
      wr_addr_d = idx_q;
      wr_data_d = wr_val_q;
      case (state_q)
         ST_CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = inf_point;
         end
         ST_LOAD:  rd_en_d = 1'b1;
         ST_WRITE: wr_en_d = 1'b1;
         ST_DRAIN_RD: begin
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q;
         end
         ST_DRAIN: begin
            wr_en_d   = out_ready;
            wr_addr_d = ptr_q;
            wr_data_d = inf_point;
         end
         default: ;
      endcase
      // A reset in the same cycle aborts any pending writeback or drain clear.
      if (Reset) begin
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q       <= ST_CLEAR;
         ptr_q         <= '0;
         idx_q         <= '0;
         q_q           <= inf_point;
         b_q           <= inf_point;
         wr_val_q      <= inf_point;
         cnt_q         <= '0;
         add_reset_q   <= 1'b1;
         out_valid_q   <= 1'b0;
         err_double_q  <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (drain_start) begin
                  ptr_q   <= '0;
                  state_q <= ST_DRAIN_RD;
               end else if (in_valid) begin
                  q_q     <= in_point;
                  idx_q   <= in_idx;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: state_q <= ST_CHECK;
            ST_CHECK: begin
               b_q <= rd_data;
               if (pt_is_inf(q_q)) begin
                  state_q <= ST_IDLE;
               end else if (pt_is_inf(rd_data)) begin
                  wr_val_q <= q_q;
                  state_q  <= ST_WRITE;
               end else if (rd_data.x == q_q.x && rd_data.y != q_q.y) begin
                  wr_val_q <= inf_point;
                  state_q  <= ST_WRITE;
               end else if (rd_data == q_q) begin
                  err_double_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end else begin
                  state_q <= ST_ARM;
               end
            end
            ST_ARM: begin
               cnt_q       <= '0;
               add_reset_q <= 1'b0;
               state_q     <= ST_ADD;
            end
            ST_ADD: begin
               // Done seen in the first ADD cycle is left over from the previous add.
               if (cnt_q != '0 && add_done) begin
                  wr_val_q    <= add_R;
                  add_reset_q <= 1'b1;
                  state_q     <= ST_WRITE;
               end else if (cnt_q == LAST_CNT) begin
                  err_timeout_q <= 1'b1;
                  add_reset_q   <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WRITE: state_q <= ST_IDLE;
            ST_DRAIN_RD: begin
               out_valid_q <= 1'b1;
               state_q     <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  ptr_q       <= ptr_q + 1'b1;
                  state_q     <= (ptr_q == LAST_IDX) ? ST_IDLE : ST_DRAIN_RD;
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign in_ready    = (state_q == ST_IDLE) && !drain_start;
   assign busy        = (state_q != ST_IDLE);
   assign out_valid   = out_valid_q;
   assign out_point   = rd_data;
   assign out_idx     = ptr_q;
   assign add_reset   = add_reset_q;
   assign add_P       = b_q;
   assign add_Q       = q_q;
   assign err_double  = err_double_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_msm_bucket_accumulator.sv
// Bench for msm_bucket_accumulator: behavioural adder with adjustable latency,
// directed vector table, hand-written corner sequences and a randomized run.
module tb_msm_bucket_accumulator;
   import elliptic_curve_structs::*;

   localparam int NB   = 16;
   localparam int IW   = 4;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           Reset       = 1'b1;
   logic           in_valid    = 1'b0;
   curve_point_t   in_point    = inf_point;
   logic [IW-1:0]  in_idx      = '0;
   logic           drain_start = 1'b0;
   logic           out_ready   = 1'b0;
   logic           in_ready, out_valid, add_reset, add_done;
   logic           err_double, err_timeout, busy;
   curve_point_t   out_point, add_P, add_Q, add_R;
   logic [IW-1:0]  out_idx;

   msm_bucket_accumulator #(
      .NUM_BUCKETS    (NB),
      .IDX_W          (IW),
      .MAX_ADD_CYCLES (MAXC)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_point    (in_point),
      .in_idx      (in_idx),
      .drain_start (drain_start),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_point   (out_point),
      .out_idx     (out_idx),
      .add_reset   (add_reset),
      .add_P       (add_P),
      .add_Q       (add_Q),
      .add_done    (add_done),
      .add_R       (add_R),
      .err_double  (err_double),
      .err_timeout (err_timeout),
      .busy        (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic curve_point_t pt_add(input curve_point_t p, input curve_point_t q);
      curve_point_t r;
      r.x = p.x + q.x;
      r.y = p.y + q.y + 1;
      return r;
   endfunction

   function automatic curve_point_t mk(input int x, input int y);
      curve_point_t r;
      r.x = COORD_W'(x);
      r.y = COORD_W'(y);
      return r;
   endfunction

   // Behavioural point adder: Done keeps its stale value through reset and the first run cycle.
   int           add_lat = 20;
   int           m_cnt   = 0;
   logic         m_done  = 1'b0;
   curve_point_t m_r     = inf_point;
   assign add_done = m_done;
   assign add_R    = m_r;
   always @(posedge clk) begin
      if (add_reset) begin
         m_cnt <= 0;
      end else begin
         if (m_cnt == 0) m_done <= 1'b0;
         if (m_cnt + 1 == add_lat) begin
            m_done <= 1'b1;
            m_r    <= pt_add(add_P, add_Q);
         end
         m_cnt <= m_cnt + 1;
      end
   end

   int           add_starts  = 0;
   int           add_low     = 0;
   logic         prev_ar     = 1'b1;
   logic         op_unstable = 1'b0;
   curve_point_t cap_p = inf_point, cap_q = inf_point;
   always @(negedge clk) begin
      if (!add_reset) begin
         if (prev_ar) begin
            add_starts++;
            cap_p = add_P;
            cap_q = add_Q;
         end else if (add_P !== cap_p || add_Q !== cap_q) begin
            op_unstable = 1'b1;
         end
         add_low++;
      end
      prev_ar = add_reset;
   end

   curve_point_t  beat_pt  [NB];
   logic [IW-1:0] beat_idx [NB];
   int            beats;
   curve_point_t  mdl      [NB];
   int            clear_n;
   logic          first_busy, first_ar, first_ov;

   task automatic do_reset();
      @(posedge clk);
      #1 Reset = 1'b1;
      in_valid = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1 Reset = 1'b0;
   endtask

   task automatic measure_clear();
      clear_n = 0;
      @(negedge clk);
      first_busy = busy; first_ar = add_reset; first_ov = out_valid;
      while (!in_ready && clear_n < 100) begin
         clear_n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         n++;
         @(negedge clk);
      end
      if (busy) bound_fail("wait_idle");
   endtask

   task automatic send(input curve_point_t p, input logic [IW-1:0] idx, input logic wait_done);
      int n = 0;
      logic ok = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b1; in_point = p; in_idx = idx;
      while (n < 200) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      if (!ok) bound_fail("send_accept");
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (ok && wait_done) wait_idle(6000);
   endtask

   task automatic drain(input int stall_beat);
      int n = 0;
      int stall = 0;
      curve_point_t hold_pt = inf_point;
      logic [IW-1:0] hold_idx = '0;
      logic stable = 1'b1;
      beats = 0;
      @(posedge clk);
      #1 drain_start = 1'b1;
      @(posedge clk);
      #1 drain_start = 1'b0;
      while (beats < NB && n < 2000) begin
         @(negedge clk);
         n++;
         if (out_valid) begin
            if (beats == stall_beat && stall < 10) begin
               if (stall == 0) begin
                  hold_pt = out_point; hold_idx = out_idx;
               end else if (out_point !== hold_pt || out_idx !== hold_idx) begin
                  stable = 1'b0;
               end
               out_ready = 1'b0;
               stall++;
            end else begin
               if (beats == stall_beat && (out_point !== hold_pt || out_idx !== hold_idx))
                  stable = 1'b0;
               out_ready = 1'b1;
               beat_pt[beats]  = out_point;
               beat_idx[beats] = out_idx;
               beats++;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
      if (beats < NB) bound_fail("drain_beats");
      if (stall_beat >= 0) check("stall_stable", 64'(stable), 64'(1));
      wait_idle(100);
      out_ready = 1'b0;
   endtask

   task automatic check_drain(input string name);
      logic idx_ok = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (beat_idx[i] !== IW'(i)) idx_ok = 1'b0;
         check($sformatf("%s_bucket%0d", name, i), beat_pt[i], mdl[i]);
      end
      check({name, "_idx_order"}, 64'(idx_ok), 64'(1));
   endtask

   typedef struct {
      curve_point_t  p1;
      curve_point_t  p2;
      logic [IW-1:0] idx;
      int            exp_adds;
      logic          exp_double;
      curve_point_t  exp_bucket;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int s0, l0, acc_a, acc_b, cyc, n;
      logic exp_dbl;
      curve_point_t p;
      logic [IW-1:0] ix;

      vecs[0] = '{mk(5,7), inf_point, 4'd3, 0, 1'b0, mk(5,7)};
      vecs[1] = '{mk(5,7), mk(9,2),   4'd3, 1, 1'b0, mk(14,10)};
      vecs[2] = '{mk(5,7), mk(5,11),  4'd1, 0, 1'b0, inf_point};
      vecs[3] = '{mk(5,7), mk(5,7),   4'd2, 0, 1'b1, mk(5,7)};

      // Power-on: one reset cycle, then the clear sweep.
      @(posedge clk);
      #1 Reset = 1'b0;
      measure_clear();
      check("clear_cycles", 64'(clear_n), 64'(16));
      check("reset_busy", 64'(first_busy), 64'(1));
      check("reset_add_reset", 64'(first_ar), 64'(1));
      check("reset_out_valid", 64'(first_ov), 64'(0));
      check("reset_err_double", 64'(err_double), 64'(0));
      check("reset_err_timeout", 64'(err_timeout), 64'(0));
      check("reset_add_P", add_P, inf_point);
      check("reset_add_Q", add_Q, inf_point);
      for (int i = 0; i < NB; i++) mdl[i] = inf_point;
      drain(-1);
      check_drain("por");

      // drain_start and in_valid together: drain wins, pair is not taken.
      @(posedge clk);
      #1 drain_start = 1'b1; in_valid = 1'b1; in_point = mk(3,3); in_idx = 4'd0;
      @(negedge clk);
      check("drain_wins_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1 drain_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      wait_idle(200);
      out_ready = 1'b0;
      drain(-1);
      check_drain("drain_wins");

      // Directed table.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         measure_clear();
         add_lat = 20;
         s0 = add_starts;
         l0 = add_low;
         send(vecs[v].p1, vecs[v].idx, 1'b1);
         send(vecs[v].p2, vecs[v].idx, 1'b1);
         check($sformatf("v%0d_add_count", v), 64'(add_starts - s0), 64'(vecs[v].exp_adds));
         check($sformatf("v%0d_add_low_none", v), 64'(add_low == l0), 64'(vecs[v].exp_adds == 0));
         if (vecs[v].exp_adds != 0) begin
            check($sformatf("v%0d_add_P", v), cap_p, vecs[v].p1);
            check($sformatf("v%0d_add_Q", v), cap_q, vecs[v].p2);
         end
         check($sformatf("v%0d_err_double", v), 64'(err_double), 64'(vecs[v].exp_double));
         check($sformatf("v%0d_err_timeout", v), 64'(err_timeout), 64'(0));
         for (int i = 0; i < NB; i++) mdl[i] = inf_point;
         mdl[vecs[v].idx] = vecs[v].exp_bucket;
         drain(-1);
         check_drain($sformatf("v%0d", v));
      end

      // Best-case accept-to-accept spacing with in_valid held high.
      do_reset();
      measure_clear();
      acc_a = -1; acc_b = -1; cyc = 0;
      @(posedge clk);
      #1 in_valid = 1'b1; in_point = mk(1,1); in_idx = 4'd9;
      while (acc_b < 0 && cyc < 50) begin
         @(negedge clk);
         if (in_ready) begin
            if (acc_a < 0) acc_a = cyc; else acc_b = cyc;
            @(posedge clk);
            #1 in_idx = 4'd10;
            cyc++;
         end else begin
            cyc++;
         end
      end
      in_valid = 1'b0;
      wait_idle(100);
      check("accept_spacing", 64'(acc_b - acc_a), 64'(4));

      // Watchdog: adder slower than the limit.
      do_reset();
      measure_clear();
      add_lat = 5000;
      send(mk(5,7), 4'd6, 1'b1);
      l0 = add_low;
      send(mk(9,2), 4'd6, 1'b1);
      check("timeout_flag", 64'(err_timeout), 64'(1));
      check("timeout_err_double", 64'(err_double), 64'(0));
      check("timeout_add_cycles", 64'(add_low - l0), 64'(MAXC));
      check("timeout_add_reset", 64'(add_reset), 64'(1));
      for (int i = 0; i < NB; i++) mdl[i] = inf_point;
      mdl[6] = mk(5,7);
      drain(-1);
      check_drain("timeout");
      check("timeout_sticky", 64'(err_timeout), 64'(1));

      // Reset in the middle of an add, then a drain with a stalled beat.
      do_reset();
      measure_clear();
      add_lat = 20;
      send(mk(5,7), 4'd8, 1'b1);
      send(mk(9,2), 4'd8, 1'b0);
      n = 0;
      while (add_reset && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (add_reset) bound_fail("mid_add_wait");
      repeat (3) @(negedge clk);
      do_reset();
      measure_clear();
      check("mid_add_clear_cycles", 64'(clear_n), 64'(16));
      check("mid_add_add_reset", 64'(add_reset), 64'(1));
      check("mid_add_errs", {62'd0, err_double, err_timeout}, 64'(0));
      for (int i = 0; i < NB; i++) mdl[i] = inf_point;
      drain(5);
      check_drain("mid_add");

      // Randomized accumulation against a plain bucket model.
      do_reset();
      measure_clear();
      for (int i = 0; i < NB; i++) mdl[i] = inf_point;
      exp_dbl = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(7) == 0) p = inf_point;
         else p = mk(int'($urandom_range(3)), int'($urandom_range(3)));
         ix = IW'($urandom_range(3));
         add_lat = int'($urandom_range(30, 2));
         send(p, ix, 1'b1);
         if (p == inf_point) begin
         end else if (mdl[ix] == inf_point) begin
            mdl[ix] = p;
         end else if (mdl[ix].x == p.x && mdl[ix].y != p.y) begin
            mdl[ix] = inf_point;
         end else if (mdl[ix] == p) begin
            exp_dbl = 1'b1;
         end else begin
            mdl[ix] = pt_add(mdl[ix], p);
         end
      end
      check("rand_err_double", 64'(err_double), 64'(exp_dbl));
      check("rand_err_timeout", 64'(err_timeout), 64'(0));
      drain(-1);
      check_drain("rand");
      check("operands_stable", 64'(op_unstable), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
